// File: rtl/mul_req_arbiter_pkg.sv
// Shared types and default constants for the multiplier request arbiter.
package mul_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 15;

    // Requester id width; at least one bit so the id port always exists.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDW = id_width(DEF_NREQ);

endpackage

// File: rtl/mul_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo NREQ.
module rr_pick
    import mul_req_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int unsigned      j;
    logic [NREQ-1:0]  sh;

    // Walk candidates in priority order starting at the pointer; first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        sh    = '0;
        for (int i = 0; i < NREQ; i++) begin
            j  = (int'(ptr_i) + i) % NREQ;
            sh = req_i >> j;
            if (!any_o && sh[0]) begin
                any_o = 1'b1;
                idx_o = IDW'(j);
                gnt_o = NREQ'(1) << j;
            end
        end
    end

endmodule

// File: rtl/mul_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one multiplier among NREQ requesters.
// Operands are latched on accept and held on the multiplier inputs until the
// response is taken; a watchdog turns a missing done into an error response.
module mul_req_arbiter
    import mul_req_arbiter_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_a,
    input  logic [NREQ*DW-1:0]       req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     mul_start,
    output logic [DW-1:0]            mul_a,
    output logic [DW-1:0]            mul_b,
    input  logic                     mul_done,
    input  logic                     mul_err,
    input  logic [2*DW-1:0]          mul_product,
    output logic                     rsp_valid,
    output logic [id_width(NREQ)-1:0] rsp_id,
    output logic [2*DW-1:0]          rsp_data,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int IDW = id_width(NREQ);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  T_MAX  = TW'(TIMEOUT);
    localparam logic [IDW-1:0] ID_TOP = IDW'(NREQ - 1);

    state_e             state_q,  state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q,     id_d;
    logic [DW-1:0]      a_q,      a_d;
    logic [DW-1:0]      b_q,      b_d;
    logic [TW-1:0]      timer_q,  timer_d;
    logic [2*DW-1:0]    data_q,   data_d;
    logic               err_q,    err_d;

    logic [NREQ-1:0]    pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Outputs decoded from state; req_ready is also forced low while in reset.
    always_comb begin
        req_ready = (state_q == ST_IDLE && rst) ? pick_gnt : '0;
        mul_start = (state_q == ST_ISSUE);
        mul_a     = a_q;
        mul_b     = b_q;
        rsp_valid = (state_q == ST_RESP);
        rsp_id    = id_q;
        rsp_data  = data_q;
        rsp_err   = err_q;
        busy      = (state_q != ST_IDLE);
    end

    // Next-state logic: accept, issue, wait with watchdog, hold response.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        timer_d  = timer_q;
        data_d   = data_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_idx;
                    a_d     = DW'(req_a >> (DW * int'(pick_idx)));
                    b_d     = DW'(req_b >> (DW * int'(pick_idx)));
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer_q != T_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
                // done qualified by err is not a completion; keep timing.
                if (mul_done && !mul_err) begin
                    data_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == T_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == ID_TOP) ? '0 : id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; async active-low reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            timer_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mul_req_arbiter.sv
// Directed bench for mul_req_arbiter: transaction table plus hand sequences
// for timeout, stray done / back-pressure and mid-operation reset.
module tb_mul_req_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_done;
    logic        mul_err;
    logic [15:0] mul_product;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic        busy;

    int tests;
    int fails;

    mul_req_arbiter #(.NREQ(4), .DW(8), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_err     (mul_err),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  valid;
        int          exp_id;
        logic [15:0] exp_data;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] opa[4];
    logic [7:0] opb[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Never more than one ready bit in any cycle.
    always @(negedge clk) begin
        tests++;
        if ($countones(req_ready) > 1) begin
            fails++;
            $display("FAIL onehot: req_ready=0x%0h expected at most one bit", req_ready);
        end
    end

    // One full transaction with the model multiplier finishing 6 cycles after start.
    task automatic do_txn(input vec_t v);
        logic [3:0] exp_gnt;
        exp_gnt   = 4'b0001 << v.exp_id;
        req_valid = v.valid;
        rsp_ready = 1'b1;
        mul_done  = 1'b0;
        mul_err   = 1'b0;
        #1;
        chk("grant", 32'(req_ready), 32'(exp_gnt));
        tick();
        chk("start_after_accept", 32'(mul_start), 32'd1);
        chk("req_ready_issue", 32'(req_ready), 32'd0);
        chk("mul_a_issue", 32'(mul_a), 32'(opa[v.exp_id]));
        chk("mul_b_issue", 32'(mul_b), 32'(opb[v.exp_id]));
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("wait_quiet", {mul_start, rsp_valid, mul_a, mul_b},
                {1'b0, 1'b0, opa[v.exp_id], opb[v.exp_id]});
        end
        tick();
        mul_product = 16'(mul_a) * 16'(mul_b);
        mul_done    = 1'b1;
        tick();
        mul_done    = 1'b0;
        mul_product = 16'hDEAD;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(v.exp_id));
        chk("rsp_data", 32'(rsp_data), 32'(v.exp_data));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("mul_a_resp", {mul_a, mul_b}, {opa[v.exp_id], opb[v.exp_id]});
        tick();
        chk("idle_after_rsp", {busy, rsp_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        opa = '{8'h0F, 8'h23, 8'hA5, 8'hFF};
        opb = '{8'h11, 8'h07, 8'h3C, 8'hFF};
        tbl[0] = '{4'b1111, 0, 16'h00FF};
        tbl[1] = '{4'b1111, 1, 16'h00F5};
        tbl[2] = '{4'b1111, 2, 16'h26AC};
        tbl[3] = '{4'b1111, 3, 16'hFE01};
        tbl[4] = '{4'b1111, 0, 16'h00FF};
        tbl[5] = '{4'b0001, 0, 16'h00FF};
        tbl[6] = '{4'b0010, 1, 16'h00F5};
        tbl[7] = '{4'b1001, 3, 16'hFE01};
        tbl[8] = '{4'b1001, 0, 16'h00FF};

        rst         = 1'b1;
        req_valid   = 4'b0000;
        req_a       = {8'hFF, 8'hA5, 8'h23, 8'h0F};
        req_b       = {8'hFF, 8'h3C, 8'h07, 8'h11};
        mul_done    = 1'b0;
        mul_err     = 1'b0;
        mul_product = 16'h0000;
        rsp_ready   = 1'b1;
        #2 rst = 1'b0;
        req_valid = 4'b1111;
        #2;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_outs", {busy, mul_start, rsp_valid, rsp_err, rsp_id},
            {1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        chk("reset_data", {mul_a, mul_b, rsp_data}, 32'd0);
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // Table: round robin over four, then single and sparse requesters.
        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i]);
        end

        // Timeout: rr_ptr is 1, requester 2 is granted, done never comes.
        req_valid = 4'b0100;
        #1;
        chk("to_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("to_start", 32'(mul_start), 32'd1);
        tick();
        for (int k = 0; k < 15; k++) begin
            chk("to_no_rsp_early", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_data", 32'(rsp_data), 32'd0);
        chk("to_rsp_id", 32'(rsp_id), 32'd2);
        tick();
        chk("to_idle", 32'(busy), 32'd0);

        // Stray done in ISSUE, done+err in WAIT, then back-pressure in RESP.
        req_valid = 4'b0001;
        #1;
        chk("st_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid   = 4'b0000;
        mul_done    = 1'b1;
        mul_product = 16'h1234;
        chk("st_issue", 32'(mul_start), 32'd1);
        tick();
        chk("st_issue_done_ignored", 32'(rsp_valid), 32'd0);
        mul_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st_err_done_ignored", 32'(rsp_valid), 32'd0);
        end
        mul_done = 1'b0;
        mul_err  = 1'b0;
        tick();
        chk("st_still_wait", {busy, rsp_valid}, 2'b10);
        mul_product = 16'(mul_a) * 16'(mul_b);
        mul_done    = 1'b1;
        rsp_ready   = 1'b0;
        tick();
        mul_done    = 1'b0;
        mul_product = 16'hBEEF;
        req_valid   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_fields", {rsp_valid, rsp_err, rsp_id, rsp_data},
                {1'b1, 1'b0, 2'd0, 16'h00FF});
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        tick();
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset mid-WAIT: rr_ptr is 1 here, requester 2 granted.
        req_valid = 4'b0100;
        #1;
        chk("rs_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        chk("rs_in_wait", {busy, mul_a}, {1'b1, 8'hA5});
        req_valid = 4'b1111;
        #2 rst = 1'b0;
        #1;
        chk("rs_outs_zero", {busy, mul_start, rsp_valid, rsp_err, rsp_id, req_ready},
            10'd0);
        chk("rs_data_zero", {mul_a, mul_b, rsp_data}, 32'd0);
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        mul_product = 16'h5555;
        mul_done    = 1'b1;
        tick();
        mul_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("rs_no_rsp", {busy, rsp_valid}, 2'b00);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        chk("rs_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
